// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer and its ALU.
package alu_seq_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 3;

    // Opcodes 0..7 are the ALU_Sel encoding. LOADI is handled by the sequencer.
    typedef enum logic [OP_W-1:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        AND   = 4'd2,
        OR    = 4'd3,
        XOR   = 4'd4,
        NOT   = 4'd5,
        SHL   = 4'd6,
        SHR   = 4'd7,
        LOADI = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [OP_W-1:0] OP_LOADI = 4'b1000;

    // Bit positions inside rsp_flags = {Overflow, Carry, Zero}.
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 2;

    // Response payload produced at the end of EXEC.
    typedef struct packed {
        logic              err;
        logic [FLAG_W-1:0] flags;
        logic [DATA_W-1:0] data;
    } rsp_t;

    // Opcodes with the MSB clear go to the ALU.
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return ~op[OP_W-1];
    endfunction

endpackage

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU.
// Ports: a/b operands, sel operation (op_e 0..7). The outputs are result_c and carry_c
// (carry for ADD/SHL/SHR, borrow for SUB), zero_c, and overflow_c (signed ADD/SUB).
module alu_8bit
    import alu_seq_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   sel,
    output logic [DATA_W-1:0] result_c,
    output logic              carry_c,
    output logic              zero_c,
    output logic              overflow_c
);

    logic [DATA_W:0] sum;

    // Operation decode; unknown selects produce zero.
    always_comb begin
        sum        = '0;
        result_c   = '0;
        carry_c    = 1'b0;
        overflow_c = 1'b0;
        case (op_e'(sel))
            ADD: begin
                sum        = {1'b0, a} + {1'b0, b};
                result_c   = sum[DATA_W-1:0];
                carry_c    = sum[DATA_W];
                overflow_c = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            SUB: begin
                sum        = {1'b0, a} - {1'b0, b};
                result_c   = sum[DATA_W-1:0];
                carry_c    = sum[DATA_W];
                overflow_c = (a[DATA_W-1] != b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            AND: result_c = a & b;
            OR:  result_c = a | b;
            XOR: result_c = a ^ b;
            NOT: result_c = ~a;
            SHL: begin
                result_c = {a[DATA_W-2:0], 1'b0};
                carry_c  = a[DATA_W-1];
            end
            SHR: begin
                result_c = {1'b0, a[DATA_W-1:1]};
                carry_c  = a[0];
            end
            default: result_c = '0;
        endcase
    end

    assign zero_c = (result_c == '0);

endmodule

// File: rtl/alu_regfile.sv
// NREGS x 8 register file: two asynchronous read ports, one synchronous write port.
// Ports: clk, rst (async, active high, clears all registers), we/waddr/wdata write port,
// and raddr1/raddr2 with combinational rdata1_c/rdata2_c read data.
module alu_regfile
    import alu_seq_pkg::*;
#(
    parameter  int unsigned NREGS = 8,
    localparam int unsigned RAW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RAW-1:0]    waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RAW-1:0]    raddr1,
    output logic [DATA_W-1:0] rdata1_c,
    input  logic [RAW-1:0]    raddr2,
    output logic [DATA_W-1:0] rdata2_c
);

    logic [DATA_W-1:0] regs [NREGS];

    // Write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1_c = regs[raddr1];
    assign rdata2_c = regs[raddr2];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-side initiator for an external combinational 8-bit ALU.
// Accepts one register-addressed command over cmd_valid/cmd_ready. The operands are read
// from the internal register file and driven onto ALU_A/ALU_B/ALU_Sel. The ALU result (or
// the immediate for LOADI) is written back to rd, and a response is returned over
// rsp_valid/rsp_ready with rsp_data, rsp_flags {V,C,Z} and rsp_err (illegal opcode).
// Each command takes IDLE -> EXEC -> RESP, so the minimum is 3 cycles per command.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter  int unsigned NREGS = 8,
    localparam int unsigned RAW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [RAW-1:0]    cmd_rd,
    input  logic [RAW-1:0]    cmd_rs1,
    input  logic [RAW-1:0]    cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic [OP_W-1:0]   ALU_Sel,
    input  logic [DATA_W-1:0] ALU_Result,
    input  logic              ALU_Carry,
    input  logic              ALU_Zero,
    input  logic              ALU_Overflow,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic              rsp_err
);

    state_e            state;
    state_e            state_nxt;
    logic              accept_c;
    logic              wr_en_c;
    rsp_t              exec_rsp_c;
    logic [RAW-1:0]    rd_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] rs1_data_c;
    logic [DATA_W-1:0] rs2_data_c;

    assign accept_c = cmd_valid & cmd_ready;

    alu_regfile #(.NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wr_en_c),
        .waddr    (rd_q),
        .wdata    (exec_rsp_c.data),
        .raddr1   (cmd_rs1),
        .rdata1_c (rs1_data_c),
        .raddr2   (cmd_rs2),
        .rdata2_c (rs2_data_c)
    );

    // State register; cmd_ready/rsp_valid are flopped decodes of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == IDLE);
            rsp_valid <= (state_nxt == RESP);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // EXEC outcome: the writeback value doubles as the response payload.
    always_comb begin
        exec_rsp_c = '0;
        wr_en_c    = 1'b0;
        if (state == EXEC) begin
            if (is_alu_op(op_q)) begin
                wr_en_c                  = 1'b1;
                exec_rsp_c.data          = ALU_Result;
                exec_rsp_c.flags[FLAG_V] = ALU_Overflow;
                exec_rsp_c.flags[FLAG_C] = ALU_Carry;
                exec_rsp_c.flags[FLAG_Z] = ALU_Zero;
            end else if (op_q == OP_LOADI) begin
                wr_en_c                  = 1'b1;
                exec_rsp_c.data          = imm_q;
                exec_rsp_c.flags[FLAG_Z] = (imm_q == '0);
            end else begin
                exec_rsp_c.err = 1'b1;
            end
        end
    end

    // Operand issue on accept; the ALU bus holds its value between commands.
    // The response is captured at the end of EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_A     <= '0;
            ALU_B     <= '0;
            ALU_Sel   <= '0;
            rd_q      <= '0;
            op_q      <= '0;
            imm_q     <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept_c) begin
                ALU_A   <= rs1_data_c;
                ALU_B   <= rs2_data_c;
                ALU_Sel <= cmd_op;
                rd_q    <= cmd_rd;
                op_q    <= cmd_op;
                imm_q   <= cmd_imm;
            end
            if (state == EXEC) begin
                rsp_data  <= exec_rsp_c.data;
                rsp_flags <= exec_rsp_c.flags;
                rsp_err   <= exec_rsp_c.err;
            end
        end
    end

endmodule
